chacha_progmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port on-chip program/data RAM (32-bit words, 15-bit word address, 23040 words, 1-cycle read latency) between the Nios data master (port 0) and the ChaCha20 engine's key/nonce/block fetch-store master (port 1).
- Sits between both Avalon-MM masters and the RAM slave. Presents pipelined Avalon interfaces (waitrequest + readdatavalid) to the masters.
- Drives address, byteenable, chipselect, write and clken on the RAM.

---
 rtl/chacha_progmem_arbiter.sv | 128 ++++++++++++
 tb/tb_chacha_progmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_progmem_arbiter.sv
// Two-master arbiter for the shared program/data RAM (Nios data + ChaCha20 fetch/store).
// Pipelined Avalon toward both masters, single-cycle-latency RAM behind.
module chacha_progmem_arbiter #(
  parameter int unsigned DEPTH     = 23040,
  parameter int unsigned BURST_MAX = 4,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  output logic [31:0] m0_readdata,
  input  logic [14:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  output logic [31:0] m1_readdata,
  output logic [14:0] ram_address,
  output logic [3:0]  ram_byteenable,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [31:0] ram_writedata,
  output logic        ram_clken,
  input  logic [31:0] ram_readdata,
  output logic        oor_err,
  input  logic        oor_clr
);

  localparam int SW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] BMAX = SW'(BURST_MAX);
  localparam logic [15:0] LIM = 16'(DEPTH);

  logic          r_rd_pend;
  logic          r_rd_port;
  logic          r_rd_oor;
  logic [SW-1:0] r_streak;
  logic          r_last;
  logic          r_oor_err;

  logic        w_req0;
  logic        w_req1;
  logic        w_valid;
  logic        w_gnt1;
  logic [14:0] w_addr;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_wr;
  logic        w_oor;
  logic [31:0] w_rdata;

  assign w_req0  = m0_read | m0_write;
  assign w_req1  = m1_read | m1_write;
  assign w_valid = reset_n & (w_req0 | w_req1);

  // Contention alternates; a streak only grows while the other port is
  // idle, so the first contention after BURST_MAX always flips.
  assign w_gnt1 = w_req1 & (~w_req0 | ~r_last);

  always_comb begin
    w_addr  = m0_address;
    w_be    = m0_byteenable;
    w_wdata = m0_writedata;
    w_wr    = m0_write;
    if (w_gnt1) begin
      w_addr  = m1_address;
      w_be    = m1_byteenable;
      w_wdata = m1_writedata;
      w_wr    = m1_write;
    end
  end

  assign w_oor = {1'b0, w_addr} >= LIM;

  assign ram_clken      = reset_n;
  assign ram_chipselect = w_valid & ~w_oor;
  assign ram_write      = w_valid & ~w_oor & w_wr;
  assign ram_address    = w_valid ? w_addr : '0;
  assign ram_byteenable = w_valid ? w_be : '0;
  assign ram_writedata  = w_valid ? w_wdata : '0;

  assign m0_waitrequest = ~reset_n | (w_req0 & w_gnt1);
  assign m1_waitrequest = ~reset_n | (w_req1 & ~w_gnt1);

  assign w_rdata = r_rd_oor ? ERR_RDATA : ram_readdata;

  assign m0_readdatavalid = r_rd_pend & ~r_rd_port;
  assign m1_readdatavalid = r_rd_pend & r_rd_port;
  assign m0_readdata = m0_readdatavalid ? w_rdata : '0;
  assign m1_readdata = m1_readdatavalid ? w_rdata : '0;

  assign oor_err = r_oor_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend <= 1'b0;
      r_rd_port <= 1'b0;
      r_rd_oor  <= 1'b0;
      r_streak  <= '0;
      r_last    <= 1'b1;
      r_oor_err <= 1'b0;
    end else begin
      r_rd_pend <= w_valid & ~w_wr;
      r_rd_port <= w_gnt1;
      r_rd_oor  <= w_valid & w_oor;
      if (w_valid) begin
        if (w_gnt1 == r_last) begin
          if (r_streak != BMAX) r_streak <= r_streak + SW'(1);
        end else begin
          r_streak <= SW'(1);
          r_last   <= w_gnt1;
        end
      end else begin
        r_streak <= '0;
      end
      if (w_valid & w_oor) r_oor_err <= 1'b1;
      else if (oor_clr)    r_oor_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha_progmem_arbiter.sv
// Scoreboard bench for chacha_progmem_arbiter with a behavioural RAM.
// Stimulus pushes expected reads; a negedge monitor pops and compares.
module tb_chacha_progmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [14:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic        m0_waitrequest;
  logic        m0_readdatavalid;
  logic [31:0] m0_readdata;
  logic [14:0] m1_address;
  logic [3:0]  m1_byteenable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic        m1_waitrequest;
  logic        m1_readdatavalid;
  logic [31:0] m1_readdata;
  logic [14:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata;
  logic        oor_err;
  logic        oor_clr;

  chacha_progmem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_readdata      (m1_readdata),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .oor_err          (oor_err),
    .oor_clr          (oor_clr)
  );

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cnt   = 0;

  logic [14:0] a0 = 15'h0200;
  logic [14:0] a1 = 15'h0300;

  logic [31:0] mem [0:23039];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [31:0] pat(input logic [14:0] a);
    return {16'hC0DE, 1'b0, a};
  endfunction

  initial begin
    for (int i = 0; i < 23040; i++) mem[i] = pat(15'(i));
    ram_readdata = '0;
  end

  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b])
            mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cnt);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0_readdatavalid) begin
      if (q0.size() == 0) begin
        chk1("rdv0_unexpected", m0_readdatavalid, 1'b0);
      end else begin
        e = q0.pop_front();
        chk("rd0_data", m0_readdata, e.d);
        chk("rd0_cycle", 32'(cnt), 32'(e.cyc));
      end
    end else begin
      chk("rd0_idle_zero", m0_readdata, 32'h0);
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) begin
        chk1("rdv1_unexpected", m1_readdatavalid, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("rd1_data", m1_readdata, e.d);
        chk("rd1_cycle", 32'(cnt), 32'(e.cyc));
      end
    end else begin
      chk("rd1_idle_zero", m1_readdata, 32'h0);
    end
  end

  task automatic clr_all();
    m0_read = 0; m0_write = 0; m0_address = '0;
    m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0;
    m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic drive(input int p, input bit rd, input bit wr,
                       input logic [14:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a;
      m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a;
      m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr_all();
    for (int i = 0; i < n; i++) next();
  endtask

  task automatic wstep(input int p, input logic [14:0] a,
                       input logic [3:0] be, input logic [31:0] d,
                       input bit exp_cs);
    clr_all();
    drive(p, 1'b0, 1'b1, a, be, d);
    @(negedge clk);
    chk1("wr_wait", p == 0 ? m0_waitrequest : m1_waitrequest, 1'b0);
    chk1("wr_cs", ram_chipselect, exp_cs);
    chk1("wr_we", ram_write, exp_cs);
    next();
    clr_all();
  endtask

  task automatic rstep(input int p, input logic [14:0] a,
                       input logic [31:0] exp_d, input bit exp_cs,
                       input bit push);
    clr_all();
    drive(p, 1'b1, 1'b0, a, 4'hF, 32'h0);
    @(negedge clk);
    chk1("rd_wait", p == 0 ? m0_waitrequest : m1_waitrequest, 1'b0);
    chk1("rd_cs", ram_chipselect, exp_cs);
    chk1("rd_we", ram_write, 1'b0);
    if (push) begin
      if (p == 0) q0.push_back('{exp_d, cnt + 1});
      else        q1.push_back('{exp_d, cnt + 1});
    end
    next();
    clr_all();
  endtask

  // g: expected granted port, 2 = nobody
  task automatic step(input bit r0, input bit r1, input int g);
    clr_all();
    if (r0) drive(0, 1'b1, 1'b0, a0, 4'hF, 32'h0);
    if (r1) drive(1, 1'b1, 1'b0, a1, 4'hF, 32'h0);
    @(negedge clk);
    chk1("grant_wait0", m0_waitrequest, r0 && g != 0);
    chk1("grant_wait1", m1_waitrequest, r1 && g != 1);
    if (g == 0) begin
      chk("grant_addr0", 32'(ram_address), 32'(a0));
      q0.push_back('{pat(a0), cnt + 1});
      a0++;
    end else if (g == 1) begin
      chk("grant_addr1", 32'(ram_address), 32'(a1));
      q1.push_back('{pat(a1), cnt + 1});
      a1++;
    end
    next();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_all();
    next();
    next();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    oor_clr = 1'b0;
    clr_all();
    m0_read  = 1'b1;
    m1_write = 1'b1;
    @(negedge clk);
    chk1("rst_wait0", m0_waitrequest, 1'b1);
    chk1("rst_wait1", m1_waitrequest, 1'b1);
    chk1("rst_cs", ram_chipselect, 1'b0);
    chk1("rst_we", ram_write, 1'b0);
    chk1("rst_clken", ram_clken, 1'b0);
    chk("rst_addr", 32'(ram_address), 32'h0);
    chk("rst_wdata", ram_writedata, 32'h0);
    chk1("rst_oor", oor_err, 1'b0);
    clr_all();
    next();
    reset_n = 1'b1;
    @(negedge clk);
    chk1("run_clken", ram_clken, 1'b1);
    next();

    // basic write then read on port 0
    wstep(0, 15'h0010, 4'hF, 32'hA5A5_0001, 1'b1);
    rstep(0, 15'h0010, 32'hA5A5_0001, 1'b1, 1'b1);
    idle(2);

    // byte-lane merge on port 1
    wstep(1, 15'h0100, 4'hF, 32'h1122_3344, 1'b1);
    wstep(1, 15'h0100, 4'b0010, 32'h0000_AA00, 1'b1);
    rstep(1, 15'h0100, 32'h1122_AA44, 1'b1, 1'b1);
    idle(2);

    // port 1 builds a capped streak, then port 0 contends
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 0);
    idle(2);

    // contention from reset alternates starting with port 0
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, i % 2);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 0);
    idle(2);

    // out-of-range accesses and sticky flag
    @(negedge clk);
    chk1("oor_before", oor_err, 1'b0);
    next();
    wstep(0, 15'd23040, 4'hF, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk1("oor_after_wr", oor_err, 1'b1);
    next();
    rstep(0, 15'd32767, 32'h0000_0000, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk1("oor_held", oor_err, 1'b1);
    next();
    oor_clr = 1'b1;
    next();
    oor_clr = 1'b0;
    @(negedge clk);
    chk1("oor_cleared", oor_err, 1'b0);
    next();
    oor_clr = 1'b1;
    wstep(0, 15'd23041, 4'hF, 32'h0, 1'b0);
    oor_clr = 1'b0;
    @(negedge clk);
    chk1("oor_set_beats_clr", oor_err, 1'b1);
    next();
    idle(1);

    // reset while a port 1 read is in flight
    rstep(1, 15'h0020, 32'h0, 1'b1, 1'b0);
    reset_n  = 1'b0;
    m0_read  = 1'b1;
    m1_read  = 1'b1;
    @(negedge clk);
    chk1("mid_rst_wait0", m0_waitrequest, 1'b1);
    chk1("mid_rst_wait1", m1_waitrequest, 1'b1);
    chk1("mid_rst_rdv1", m1_readdatavalid, 1'b0);
    chk1("mid_rst_cs", ram_chipselect, 1'b0);
    next();
    next();
    reset_n = 1'b1;
    step(1'b1, 1'b1, 0);
    idle(4);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
